// File: rtl/cv32e40s_fv_obi_responder_pkg.sv
// Shared types and width helpers for the cv32e40s formal/sim OBI responder.
//   obi_resp_entry_t : one queued response (read data + error flag)
//   resp_state_e     : response-channel FSM states
//   idx_w / be_w     : word-index and byte-enable width helpers
// Response entries carry OBI_DATA_W bits of data, so the responder's
// DATA_WIDTH has to equal OBI_DATA_W.
package cv32e40s_fv_obi_pkg;

  localparam int unsigned OBI_DATA_W = 32;

  typedef struct packed {
    logic [OBI_DATA_W-1:0] rdata;
    logic                  err;
  } obi_resp_entry_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_VALID
  } resp_state_e;

  // Number of bits needed to index 'depth' items (at least 1).
  function automatic int unsigned idx_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned be_w(input int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/cv32e40s_fv_obi_responder_if.sv
// OBI bus bundle between an initiator (core side) and the responder.
//   req/gnt/addr/we/be/wdata : address phase
//   rvalid/rready/rdata/err  : response phase
// Modports: master (initiator), slave (responder).
interface cv32e40s_fv_obi_if
  import cv32e40s_fv_obi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);

  logic                          req;
  logic                          gnt;
  logic [ADDR_WIDTH-1:0]         addr;
  logic                          we;
  logic [be_w(DATA_WIDTH)-1:0]   be;
  logic [DATA_WIDTH-1:0]         wdata;
  logic                          rvalid;
  logic                          rready;
  logic [DATA_WIDTH-1:0]         rdata;
  logic                          err;

  modport master (
    output req, addr, we, be, wdata, rready,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, addr, we, be, wdata, rready,
    output gnt, rvalid, rdata, err
  );

endinterface

// File: rtl/cv32e40s_fv_obi_responder_resp_fifo.sv
// In-order response FIFO for the OBI responder.
//   clk_i, rst_i      : clock, synchronous active-high reset (empties the FIFO)
//   push_i / entry_i  : enqueue one response entry
//   pop_i             : drop the head entry
//   head_o            : current head entry
//   full_o / empty_o  : occupancy flags
//   count_o           : number of stored entries
// Pointers wrap explicitly at DEPTH, so DEPTH need not be a power of two.
module cv32e40s_fv_obi_resp_fifo
  import cv32e40s_fv_obi_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = idx_w(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  obi_resp_entry_t entry_i,
  input  logic            pop_i,
  output obi_resp_entry_t head_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CNT_W-1:0] count_o
);

  obi_resp_entry_t  mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) count_d = count_q + CNT_W'(1);
    if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage needs no reset: count_q alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= entry_i;
  end

endmodule

// File: rtl/cv32e40s_fv_obi_responder.sv
// OBI responder (memory side) for the cv32e40s formal/sim harness.
// Grants requests, services them from a small word-addressed memory and
// returns in-order responses no earlier than RESP_LATENCY cycles after accept.
//   clk_i, rst_i    : clock, synchronous active-high reset
//   obi (slave)     : OBI address and response phases
//   stall_gnt_i     : free input, 1 suppresses gnt
//   stall_rvalid_i  : free input, 1 delays rvalid assertion
// Optional feature macro FV_OBI_RESP_ERR_EN: out-of-range accesses answer
// err=1 / rdata=0 and do not write memory. Without it the address wraps
// modulo MEM_DEPTH*4 and err is tied to 0.
module cv32e40s_fv_obi_responder
  import cv32e40s_fv_obi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned MEM_DEPTH    = 64,
  parameter int unsigned OUTSTANDING  = 2,
  parameter int unsigned RESP_LATENCY = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  cv32e40s_fv_obi_if.slave   obi,
  input  logic               stall_gnt_i,
  input  logic               stall_rvalid_i
);

  localparam int unsigned IDX_W = idx_w(MEM_DEPTH);
  localparam int unsigned BE_W  = be_w(DATA_WIDTH);
  localparam int unsigned LAT_W = idx_w(RESP_LATENCY);
  localparam int unsigned CNT_W = $clog2(OUTSTANDING + 1);

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic [IDX_W-1:0]      idx;
  logic                  oor, acc_err, accept, do_write;
  logic                  fifo_full, fifo_empty, rvalid, pop;
  logic [CNT_W-1:0]      fifo_count;
  obi_resp_entry_t       push_entry, head_entry;
  resp_state_e           state_q, state_d;
  logic [LAT_W-1:0]      cnt_q, cnt_d;

  // cnt counts the cycles the current head has spent waiting (0 = first).
  function automatic logic lat_done(input logic [LAT_W-1:0] c);
    return c >= LAT_W'(RESP_LATENCY - 1);
  endfunction

  function automatic logic [LAT_W-1:0] lat_inc(input logic [LAT_W-1:0] c);
    return lat_done(c) ? c : c + LAT_W'(1);
  endfunction

  assign idx = obi.addr[IDX_W+1:2];
  assign oor = (obi.addr >> (IDX_W + 2)) != '0;

`ifdef FV_OBI_RESP_ERR_EN
  assign acc_err = oor;
`else
  assign acc_err = 1'b0;
`endif

  // full is the registered count, so a retire never frees a slot in its own cycle.
  assign obi.gnt  = obi.req & ~fifo_full & ~stall_gnt_i & ~rst_i;
  assign accept   = obi.req & obi.gnt;
  assign do_write = accept & obi.we & ~acc_err;

  // Reads sample the memory before this cycle's write, so a write accepted
  // earlier is always visible to a later read.
  always_comb begin
    push_entry.rdata = (obi.we || acc_err) ? '0 : mem_q[idx];
    push_entry.err   = acc_err;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int w = 0; w < MEM_DEPTH; w++) mem_q[w] <= '0;
    end else if (do_write) begin
      for (int b = 0; b < BE_W; b++) begin
        if (obi.be[b]) mem_q[idx][b*8 +: 8] <= obi.wdata[b*8 +: 8];
      end
    end
  end

  cv32e40s_fv_obi_resp_fifo #(
    .DEPTH (OUTSTANDING)
  ) u_resp_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (accept),
    .entry_i (push_entry),
    .pop_i   (pop),
    .head_o  (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= R_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      // An entry arriving into an empty FIFO counts its accept cycle as wait cycle 0.
      R_IDLE: begin
        if (accept || !fifo_empty) begin
          if (lat_done('0) && !stall_rvalid_i) begin
            state_d = R_VALID;
          end else begin
            state_d = R_WAIT;
            cnt_d   = lat_inc('0);
          end
        end
      end
      R_WAIT: begin
        if (lat_done(cnt_q) && !stall_rvalid_i) state_d = R_VALID;
        else                                    cnt_d   = lat_inc(cnt_q);
      end
      R_VALID: begin
        if (pop) begin
          if (fifo_count > CNT_W'(1) || accept) begin
            state_d = R_WAIT;
            cnt_d   = '0;
          end else begin
            state_d = R_IDLE;
          end
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

  always_comb begin
    rvalid    = (state_q == R_VALID) & ~rst_i;
    obi.rdata = rvalid ? head_entry.rdata : '0;
`ifdef FV_OBI_RESP_ERR_EN
    obi.err   = rvalid & head_entry.err;
`else
    obi.err   = 1'b0;
`endif
  end

  assign obi.rvalid = rvalid;
  assign pop        = rvalid & obi.rready;

endmodule
